// File: rtl/adc_pkg.sv
// Shared constants for the ADC frame header word; readout software decodes
// headers with the same field positions.
package adc_pkg;

    localparam logic [7:0] ADC_HDR_SYNC     = 8'hA5;
    localparam int         ADC_HDR_SYNC_LSB = 24;
    localparam int         ADC_HDR_NCH_LSB  = 16;
    localparam int         ADC_HDR_SEQ_LSB  = 0;

    function automatic logic [31:0] adc_make_header(input logic [7:0]  nch,
                                                    input logic [15:0] seq);
        logic [31:0] h;
        h = '0;
        h[ADC_HDR_SYNC_LSB +: 8] = ADC_HDR_SYNC;
        h[ADC_HDR_NCH_LSB  +: 8] = nch;
        h[ADC_HDR_SEQ_LSB  +: 16] = seq;
        return h;
    endfunction

endpackage

// File: rtl/adc_frame_packer_if.sv
// Word push link between the frame packer and the stream FIFO.
// valid/ready: a word moves on any cycle with push_valid && push_ready; once
// push_valid is raised it stays high and push_data stays stable until that cycle.
interface adc_frame_packer_if;

    logic        push_valid;
    logic [31:0] push_data;
    logic        push_ready;

    modport master (output push_valid, output push_data, input push_ready);
    modport slave  (input push_valid, input push_data, output push_ready);

endinterface

// File: rtl/adc_frame_packer.sv
// Captures one ADC conversion frame and serialises it as a header word plus
// one sign-extended 32-bit word per channel; frames arriving mid-drain are dropped.
module adc_frame_packer
    import adc_pkg::*;
#(
    parameter int NUM_CH      = 8,
    parameter int SAMPLE_BITS = 24
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          enable,
    input  logic                          frame_valid,
    input  logic [NUM_CH*SAMPLE_BITS-1:0] frame_data,
    output logic                          frame_ready,
    adc_frame_packer_if.master            push,
    output logic                          busy,
    output logic [15:0]                   seq_num,
    output logic                          drop_sticky,
    output logic [15:0]                   drop_count,
    input  logic                          drop_clear,
    output logic [1:0]                    state_dbg
);

    localparam int IDX_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CH - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HDR  = 2'd1,
        ST_DATA = 2'd2
    } state_t;

    state_t                 state_q, state_d;
    logic [IDX_W-1:0]       ch_q, ch_d;
    logic [SAMPLE_BITS-1:0] sample_q [NUM_CH];
    logic [15:0]            seq_q;
    logic [15:0]            hdr_seq_q;
    logic                   sticky_q;
    logic [15:0]            cnt_q;
    logic                   accept;
    logic                   drop;
    logic                   xfer;
    logic signed [SAMPLE_BITS-1:0] cur_sample;

    assign frame_ready = (state_q == ST_IDLE) && enable;
    assign accept      = frame_valid && frame_ready;
    assign drop        = frame_valid && enable && (state_q != ST_IDLE);
    assign xfer        = push.push_valid && push.push_ready;

    assign busy        = (state_q != ST_IDLE);
    assign seq_num     = seq_q;
    assign drop_sticky = sticky_q;
    assign drop_count  = cnt_q;
    assign state_dbg   = state_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            ch_q    <= '0;
        end else begin
            state_q <= state_d;
            ch_q    <= ch_d;
        end
    end

    // Outputs decode only registered state, so push_ready never reaches push_valid.
    always_comb begin
        state_d         = state_q;
        ch_d            = ch_q;
        push.push_valid = 1'b0;
        push.push_data  = '0;
        cur_sample      = sample_q[ch_q];
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    state_d = ST_HDR;
                    ch_d    = '0;
                end
            end
            ST_HDR: begin
                push.push_valid = 1'b1;
                push.push_data  = adc_make_header(8'(NUM_CH), hdr_seq_q);
                if (xfer) state_d = ST_DATA;
            end
            ST_DATA: begin
                push.push_valid = 1'b1;
                push.push_data  = 32'(cur_sample);
                if (xfer) begin
                    if (ch_q == LAST_IDX) state_d = ST_IDLE;
                    else                  ch_d    = ch_q + 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_CH; i++) begin
            if (accept) sample_q[i] <= frame_data[i*SAMPLE_BITS +: SAMPLE_BITS];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            seq_q     <= '0;
            hdr_seq_q <= '0;
        end else if (accept) begin
            hdr_seq_q <= seq_q;
            seq_q     <= seq_q + 16'd1;
        end
    end

    // A drop in the same cycle as drop_clear restarts the count at one.
    always_ff @(posedge clk) begin
        if (rst) begin
            sticky_q <= 1'b0;
            cnt_q    <= '0;
        end else if (drop) begin
            sticky_q <= 1'b1;
            if (drop_clear)             cnt_q <= 16'd1;
            else if (cnt_q != 16'hFFFF) cnt_q <= cnt_q + 16'd1;
        end else if (drop_clear) begin
            sticky_q <= 1'b0;
            cnt_q    <= '0;
        end
    end

endmodule
